fetch_pc_unit: RTL
==================

// Module: fetch_pc_unit
// PURPOSE
//  N-wide fetch PC generator for the multi-issue MIPS front end; replaces the fixed dual-lane PC controller.
//  Produces ISSUE_W consecutive lane addresses per fetch group and advances by the issued count.
//  Arbitrates exception/branch redirects, holds the address stable across an I-cache req/ready handshake,
//  and defers redirects that arrive mid-handshake. Sits between the issue/branch units and the I-cache port.
// PARAMETERS
//  ADDR_W    32             PC width
//  ISSUE_W   2              lanes per fetch group (power of 2, 1..8)
//  RESET_PC  32'hBFC0_0000  PC loaded on reset
//  CNT_W     $clog2(ISSUE_W+1)  derived width of issue_cnt
// PORTS
//  clk        in   1               clock
//  rst        in   1               synchronous reset, active-high
//  stall      in   1               back-end stall; freezes sequential advance
//  issue_cnt  in   CNT_W           instructions consumed from current group (0..ISSUE_W)
//  br_valid   in   1               branch redirect request
//  br_target  in   ADDR_W          branch target
//  exc_valid  in   1               exception/eret redirect request
//  exc_target in   ADDR_W          exception vector / EPC
//  if_req     out  1               fetch request valid to I-cache
//  if_ready   in   1               I-cache accepts request this cycle
//  pc_o       out  ISSUE_W*ADDR_W  lane i address = pc + 4*i, lane 0 in LSBs
//  lane_vld   out  ISSUE_W         lane i valid iff it lies in the same ISSUE_W*4-byte aligned block as lane 0
//  flush      out  1               one-cycle pulse: discard in-flight fetch data (redirect applied)
//  addr_err   out  1               current pc misaligned (pc[1:0]!=0)
// BEHAVIOUR
//  - Reset: pc=RESET_PC, pend=none, if_req=0, flush=0, addr_err=0; if_req=1 from the first cycle after rst drops.
//  - Redirect priority (same cycle): exc > br; losing br dropped, never queued.
//  - Stability rule: while if_req && !if_ready, pc_o, lane_vld and pc are held; issue_cnt ignored.
//  - FSM RUN: redirect with no blocked handshake -> pc=target next cycle, flush=1 that cycle.
//    Redirect while if_req && !if_ready -> latch into pend, go PEND.
//  - FSM PEND: hold pc; newer exc overwrites pend; br overwrites only a pending br.
//    On if_ready (or if_req=0) -> pc=pend target next cycle, flush=1, pend cleared, back to RUN.
//  - Sequential advance (RUN, no redirect, !stall, handshake not blocked): pc += 4*min(issue_cnt, ISSUE_W).
//    issue_cnt > ISSUE_W is clamped. Advance by 0 is legal (refetch).
//  - stall: no sequential advance; redirects still accepted/latched; if_req unchanged.
//  - Arithmetic: pc adds modulo 2^ADDR_W; 32'hFFFF_FFFC+8 -> 32'h0000_0004; lane addresses also wrap.
//  - lane_vld[i] = (pc[log2(ISSUE_W)+1:2] + i) < ISSUE_W; lane 0 always valid unless addr_err.
//  - Misaligned target: pc loaded as given; addr_err=1, if_req=0, lane_vld=0 until next redirect.
//  - rst mid-handshake or in PEND: pend discarded, pc=RESET_PC next cycle, no flush pulse.
//  - All outputs registered except pc_o/lane_vld (pure decode of pc register).
// STRUCTURE
//  - fetch_pkg: ADDR_W/ISSUE_W defaults, RESET_PC, typedef redirect_t {logic vld; logic is_exc; logic [ADDR_W-1:0] tgt;},
//    fsm enum pc_state_e {PC_RUN, PC_PEND}.
//  - Sub-module pc_redirect_arb: combinational exc/br priority + pend overwrite rule -> redirect_t.
//  - Top holds pc register, FSM, pend register, lane decode.
// TESTING
//  1 Reset release, if_ready=1, issue_cnt=2 each cycle -> pc 0xBFC00000, 0xBFC00008, 0xBFC00010; lane_vld=2'b11.
//  2 issue_cnt=1 from 0xBFC00000 -> pc 0xBFC00004, lane_vld=2'b01 (lane1 crosses block); issue_cnt=0 -> pc held.
//  3 br_valid & exc_valid same cycle, targets 0x100/0x380 -> next pc 0x380, flush=1 one cycle.
//  4 if_ready=0 with br to 0x200 -> pc held, state PEND; exc 0x380 next cycle overwrites;
//    if_ready=1 -> pc 0x380, flush=1.
//  5 pc=0xFFFFFFF8, issue_cnt=2 -> pc 0x00000000; pc_o lane1=0x00000004.
//  6 br to 0x102 -> addr_err=1, if_req=0; then br to 0x200 -> addr_err=0, if_req=1; rst in PEND -> pc=0xBFC00000.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared types for the N-wide fetch PC generator: redirect record, FSM states
// and the default geometry of the front end.
package fetch_pc_unit_pkg;

   localparam int          FETCH_ADDR_W   = 32;
   localparam int          FETCH_ISSUE_W  = 2;
   localparam logic [31:0] FETCH_RESET_PC = 32'hBFC0_0000;

   // A redirect request as seen by the PC register: exceptions outrank branches.
   typedef struct packed {
      logic                    vld;
      logic                    is_exc;
      logic [FETCH_ADDR_W-1:0] tgt;
   } redirect_t;

   typedef enum logic {
      PC_RUN,
      PC_PEND
   } pc_state_e;

   function automatic logic isAligned(input logic [1:0] lowBits);
      return lowBits == 2'b00;
   endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bundle between the issue/branch units, the PC generator and the I-cache port.
interface fetch_pc_unit_if
   import fetch_pc_unit_pkg::*;
#(
   parameter int ADDR_W  = FETCH_ADDR_W,
   parameter int ISSUE_W = FETCH_ISSUE_W
);
   localparam int CNT_W = $clog2(ISSUE_W + 1);

   logic                      stall;
   logic [CNT_W-1:0]          issue_cnt;
   logic                      br_valid;
   logic [ADDR_W-1:0]         br_target;
   logic                      exc_valid;
   logic [ADDR_W-1:0]         exc_target;
   logic                      if_req;
   logic                      if_ready;
   logic [ISSUE_W*ADDR_W-1:0] pc_o;
   logic [ISSUE_W-1:0]        lane_vld;
   logic                      flush;
   logic                      addr_err;

   modport master (
      input  stall, issue_cnt, br_valid, br_target, exc_valid, exc_target, if_ready,
      output if_req, pc_o, lane_vld, flush, addr_err
   );

   modport slave (
      output stall, issue_cnt, br_valid, br_target, exc_valid, exc_target, if_ready,
      input  if_req, pc_o, lane_vld, flush, addr_err
   );

endinterface

// File: rtl/fetch_pc_unit_redirect_arb.sv
// Chooses which redirect the PC register should act on this cycle, merging fresh
// exception/branch requests with a redirect already parked behind a blocked fetch.
module pc_redirect_arb
   import fetch_pc_unit_pkg::*;
(
   input  logic                    exc_valid_i,
   input  logic [FETCH_ADDR_W-1:0] exc_target_i,
   input  logic                    br_valid_i,
   input  logic [FETCH_ADDR_W-1:0] br_target_i,
   input  redirect_t               pend_i,
   output redirect_t               sel_o
);

   redirect_t incoming;

   // A losing branch is simply dropped; a parked exception can only be replaced by a newer exception.
   always_comb begin
      incoming = '0;
      if (exc_valid_i) begin
         incoming = '{vld: 1'b1, is_exc: 1'b1, tgt: exc_target_i};
      end else if (br_valid_i) begin
         incoming = '{vld: 1'b1, is_exc: 1'b0, tgt: br_target_i};
      end

      sel_o = pend_i;
      if (!pend_i.vld || exc_valid_i || (br_valid_i && !pend_i.is_exc)) begin
         sel_o = incoming;
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// N-wide fetch PC generator: owns the PC register, defers redirects across a stalled
// I-cache handshake and decodes per-lane addresses and valids from the PC.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter int              ADDR_W   = FETCH_ADDR_W,
   parameter int              ISSUE_W  = FETCH_ISSUE_W,
   parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC,
   parameter int              CNT_W    = $clog2(ISSUE_W + 1)
) (
   input logic             clk,
   input logic             rst,
   fetch_pc_unit_if.master bus
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   pc_state_e         state_q, state_d;
   redirect_t         pend_q, pend_d;
   logic              flush_q, flush_d;
   logic              ifReq_q, ifReq_d;
   logic              addrErr_q, addrErr_d;

   logic              blocked;
   redirect_t         sel;
   logic [CNT_W-1:0]  cntClamp;
   logic [ADDR_W-1:0] advance;
   logic [ADDR_W-1:0] blockOff;

   pc_redirect_arb u_arb (
      .exc_valid_i  (bus.exc_valid),
      .exc_target_i (bus.exc_target),
      .br_valid_i   (bus.br_valid),
      .br_target_i  (bus.br_target),
      .pend_i       (pend_q),
      .sel_o        (sel)
   );

   assign blocked  = ifReq_q && !bus.if_ready;
   assign cntClamp = (bus.issue_cnt > CNT_W'(ISSUE_W)) ? CNT_W'(ISSUE_W) : bus.issue_cnt;
   assign advance  = ADDR_W'(cntClamp) << 2;

   // Sequential advance only counts a group that was actually requested, so the
   // first cycle after reset and the misaligned-PC state both hold the PC.
   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      pend_d  = pend_q;
      flush_d = 1'b0;

      case (state_q)
         PC_RUN: begin
            if (sel.vld) begin
               if (blocked) begin
                  pend_d  = sel;
                  state_d = PC_PEND;
               end else begin
                  pc_d    = ADDR_W'(sel.tgt);
                  flush_d = 1'b1;
               end
            end else if (ifReq_q && !blocked && !bus.stall) begin
               pc_d = pc_q + advance;
            end
         end
         PC_PEND: begin
            pend_d = sel;
            if (!blocked) begin
               pc_d    = ADDR_W'(sel.tgt);
               flush_d = 1'b1;
               pend_d  = '0;
               state_d = PC_RUN;
            end
         end
         default: state_d = PC_RUN;
      endcase

      addrErr_d = !isAligned(pc_d[1:0]);
      ifReq_d   = !addrErr_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         state_q   <= PC_RUN;
         pend_q    <= '0;
         flush_q   <= 1'b0;
         ifReq_q   <= 1'b0;
         addrErr_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         state_q   <= state_d;
         pend_q    <= pend_d;
         flush_q   <= flush_d;
         ifReq_q   <= ifReq_d;
         addrErr_q <= addrErr_d;
      end
   end

   assign bus.if_req   = ifReq_q;
   assign bus.flush    = flush_q;
   assign bus.addr_err = addrErr_q;

   // Word offset of lane 0 inside its ISSUE_W*4-byte block; lanes past the block end are invalid.
   assign blockOff = (pc_q >> 2) & ADDR_W'(ISSUE_W - 1);

   for (genvar i = 0; i < ISSUE_W; i++) begin : g_lane
      assign bus.pc_o[i*ADDR_W +: ADDR_W] = pc_q + ADDR_W'(4 * i);
      assign bus.lane_vld[i] = !addrErr_q && ((blockOff + ADDR_W'(i)) < ADDR_W'(ISSUE_W));
   end

endmodule
